// File: rtl/debounce_scheduler_pkg.sv
// Shared types and helpers for the keypad debounce scheduler.
// Holds the FSM state encoding and the index-width helper.
package debounce_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } state_e;

  function automatic int idx_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_pick.sv
// Round-robin first-set-bit finder, searching from ptr upward.
// Ports: req[NB], ptr[IW] in; gnt_idx[IW], any out. Purely combinational.
module rr_pick
  import debounce_scheduler_pkg::*;
#(
  parameter int NB = 4,
  parameter int IW = idx_w(NB)
) (
  input  logic [NB-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < NB; i++) begin
      // wrap without a modulo so non-power-of-2 NB works
      j = int'(ptr) + i;
      if (j >= NB) j = j - NB;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Shares one debounce counter among NB synchronized buttons.
// Ports: clk, rst, btn[NB] in; stable[NB], busy, evt_* valid/ready out.
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int NB = 4,
  parameter int N  = 10,
  parameter int K  = 4,
  localparam int IW = idx_w(NB)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] btn,
  output logic [NB-1:0] stable,
  output logic          busy,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [IW-1:0] evt_idx,
  output logic          evt_press
);

  state_e        state;
  logic [K-1:0]  cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          tgt;

  logic [NB-1:0] diff;
  logic [IW-1:0] gnt;
  logic          any;
  logic          cur;
  logic          cnt_last;
  logic [IW-1:0] nxt_ptr;

  assign diff     = btn ^ stable;
  assign cur      = btn[sel];
  assign cnt_last = (cnt == K'(N - 1));
  assign nxt_ptr  = (sel == IW'(NB - 1)) ? '0 : sel + 1'b1;
  assign busy     = (state != IDLE);

  rr_pick #(
    .NB (NB),
    .IW (IW)
  ) u_pick (
    .req     (diff),
    .ptr     (ptr),
    .gnt_idx (gnt),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stable    <= '0;
      cnt       <= '0;
      ptr       <= '0;
      sel       <= '0;
      tgt       <= 1'b0;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_press <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            sel   <= gnt;
            tgt   <= btn[gnt];
            cnt   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          unique case (1'b1)
            (cur != tgt): begin
              // bounce: drop it and move on so others get a turn
              cnt   <= '0;
              ptr   <= nxt_ptr;
              state <= IDLE;
            end
            (cur == tgt && cnt_last): begin
              stable[sel] <= tgt;
              evt_valid   <= 1'b1;
              evt_idx     <= sel;
              evt_press   <= tgt;
              state       <= EMIT;
            end
            default: begin
              cnt <= cnt + 1'b1;
            end
          endcase
        end
        EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            cnt       <= '0;
            ptr       <= nxt_ptr;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
